// File: rtl/iodelay_sequencer.sv
// Sequences an idelay tap change: reset idelay + incrementor, settle, trigger the
// incrementor, wait for its ce burst, then verify the returned tap count.
module iodelay_sequencer #(
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int TIMEOUT       = 80
) (
    input  logic       clk40,
    input  logic       rst,
    input  logic [5:0] delay_in,
    input  logic       delay_load,
    input  logic       inc_en_in,
    input  logic [5:0] actual_delay_in,
    output logic       idelay_rst,
    output logic       count_trig,
    output logic [5:0] spec_delay,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [5:0] applied_delay
);

    typedef enum logic [2:0] {IDLE, RESET, SETTLE, TRIG, START, COUNT, CHECK} state_t;

    localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [6:0] TMO_LIM     = 7'(TIMEOUT);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [6:0] tmo, tmo_n, tmo_inc;
    logic       pend, pend_n;
    logic [5:0] pend_val, pend_val_n;
    logic       seq_err, seq_err_n;
    logic [5:0] spec_n, applied_n;
    logic       err_n, done_n;

    assign tmo_inc = (tmo == 7'h7f) ? tmo : tmo + 7'd1;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        tmo_n      = tmo;
        pend_n     = pend;
        pend_val_n = pend_val;
        seq_err_n  = seq_err;
        spec_n     = spec_delay;
        applied_n  = applied_delay;
        err_n      = err;
        done_n     = 1'b0;

        // Requests arriving mid-sequence are parked; the last one wins.
        if (delay_load && state != IDLE && state != CHECK) begin
            pend_n     = 1'b1;
            pend_val_n = delay_in;
        end

        case (state)
            IDLE: begin
                if (delay_load) begin
                    if (delay_in == applied_delay && !err) begin
                        done_n = 1'b1;
                    end else begin
                        spec_n    = delay_in;
                        err_n     = 1'b0;
                        seq_err_n = 1'b0;
                        cnt_n     = 8'd0;
                        state_n   = RESET;
                    end
                end
            end
            RESET: begin
                if (cnt == RST_LAST) begin
                    cnt_n   = 8'd0;
                    state_n = SETTLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_n   = 8'd0;
                    state_n = TRIG;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            TRIG: begin
                tmo_n   = 7'd0;
                state_n = START;
            end
            START: begin
                tmo_n = tmo_inc;
                if (inc_en_in) begin
                    state_n = COUNT;
                end else if (tmo == 7'd1) begin
                    // incrementor never answered the trigger
                    seq_err_n = 1'b1;
                    err_n     = 1'b1;
                    state_n   = CHECK;
                end
            end
            COUNT: begin
                tmo_n = tmo_inc;
                if (!inc_en_in) begin
                    state_n = CHECK;
                end else if (tmo_inc == TMO_LIM) begin
                    seq_err_n = 1'b1;
                    err_n     = 1'b1;
                    state_n   = CHECK;
                end
            end
            CHECK: begin
                done_n = 1'b1;
                if (actual_delay_in == spec_delay && !seq_err)
                    applied_n = spec_delay;
                else
                    err_n = 1'b1;
                // A load in this very cycle counts as pending and overrides the parked one.
                if (delay_load || pend) begin
                    spec_n    = delay_load ? delay_in : pend_val;
                    pend_n    = 1'b0;
                    seq_err_n = 1'b0;
                    cnt_n     = 8'd0;
                    state_n   = RESET;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk40) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            tmo           <= 7'd0;
            pend          <= 1'b0;
            pend_val      <= 6'd0;
            seq_err       <= 1'b0;
            idelay_rst    <= 1'b0;
            count_trig    <= 1'b0;
            spec_delay    <= 6'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            applied_delay <= 6'd0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            tmo           <= tmo_n;
            pend          <= pend_n;
            pend_val      <= pend_val_n;
            seq_err       <= seq_err_n;
            // Strobes decode the next state so they line up with the state register.
            idelay_rst    <= (state_n == RESET);
            count_trig    <= (state_n == TRIG);
            spec_delay    <= spec_n;
            busy          <= (state_n != IDLE);
            done          <= done_n;
            err           <= err_n;
            applied_delay <= applied_n;
        end
    end

endmodule

// File: tb/tb_iodelay_sequencer.sv
// Directed bench for iodelay_sequencer: nominal, skip, pending, timeout,
// mismatch and reset scenarios with hand-computed cycle expectations.
module tb_iodelay_sequencer;

    logic       clk40 = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] delay_in = 6'd0;
    logic       delay_load = 1'b0;
    logic       inc_en_in = 1'b0;
    logic [5:0] actual_delay_in = 6'd0;
    logic       idelay_rst, count_trig, busy, done, err;
    logic [5:0] spec_delay, applied_delay;

    int checks = 0;
    int errors = 0;
    int trig_cnt = 0;
    int rst_hi_cnt = 0;
    bit overlap = 1'b0;

    iodelay_sequencer #(.RST_CYCLES(4), .SETTLE_CYCLES(8), .TIMEOUT(80)) dut (
        .clk40(clk40), .rst(rst), .delay_in(delay_in), .delay_load(delay_load),
        .inc_en_in(inc_en_in), .actual_delay_in(actual_delay_in),
        .idelay_rst(idelay_rst), .count_trig(count_trig), .spec_delay(spec_delay),
        .busy(busy), .done(done), .err(err), .applied_delay(applied_delay)
    );

    always #5 clk40 = ~clk40;

    always @(posedge clk40) begin
        if (count_trig === 1'b1) trig_cnt = trig_cnt + 1;
        if (idelay_rst === 1'b1) rst_hi_cnt = rst_hi_cnt + 1;
        if (count_trig === 1'b1 && idelay_rst === 1'b1) overlap = 1'b1;
    end

    task automatic tick();
        @(posedge clk40);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [5:0] d);
        delay_in   = d;
        delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
    endtask

    task automatic wait_trig(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (count_trig === 1'b1) seen = 1'b1;
            else tick();
        end
        chk(tag, 32'(seen), 1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 1);
    endtask

    // Incrementor model: raise ce one cycle after the trigger, hold it, return act.
    task automatic run_incr(input int hold, input logic [5:0] act);
        tick();
        inc_en_in       = 1'b1;
        actual_delay_in = act;
        repeat (hold) tick();
        inc_en_in = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return 32'({idelay_rst, count_trig, busy, done, err, spec_delay, applied_delay});
    endfunction

    initial begin
        int t0, r0;
        rst = 1'b1;
        tick(); tick();
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        tick();

        // Nominal: load at cycle 0
        load(6'd10);                                   // cycle 1
        chk("nom_rst_c1", 32'(idelay_rst), 1);
        chk("nom_busy_c1", 32'(busy), 1);
        chk("nom_spec", 32'(spec_delay), 10);
        repeat (3) tick();                             // cycle 4
        chk("nom_rst_c4", 32'(idelay_rst), 1);
        tick();                                        // cycle 5
        chk("nom_rst_c5", 32'(idelay_rst), 0);
        repeat (7) tick();                             // cycle 12
        chk("nom_trig_c12", 32'(count_trig), 0);
        tick();                                        // cycle 13
        chk("nom_trig_c13", 32'(count_trig), 1);
        run_incr(5, 6'd10);                            // cycle 19
        tick();                                        // cycle 20 (CHECK)
        chk("nom_done_c20", 32'(done), 0);
        chk("nom_busy_c20", 32'(busy), 1);
        tick();                                        // cycle 21
        chk("nom_done_c21", 32'(done), 1);
        chk("nom_applied", 32'(applied_delay), 10);
        chk("nom_err", 32'(err), 0);
        chk("nom_busy_c21", 32'(busy), 0);
        chk("nom_rst_width", 32'(rst_hi_cnt), 4);

        // Skip: same value again, no sequence
        load(6'd10);
        chk("skip_done", 32'(done), 1);
        chk("skip_busy", 32'(busy), 0);
        chk("skip_idelay_rst", 32'(idelay_rst), 0);
        tick();
        chk("skip_done_once", 32'(done), 0);
        chk("skip_rst_width", 32'(rst_hi_cnt), 4);

        // Pending: 5, then 20 and 33 while busy -> sequences 5 then 33
        t0 = trig_cnt;
        load(6'd5);
        tick();
        load(6'd20);
        tick();
        load(6'd33);
        wait_trig("pend_trig1_seen");
        chk("pend_spec_held", 32'(spec_delay), 5);
        run_incr(3, 6'd5);
        wait_done("pend_done1_seen");
        chk("pend_applied1", 32'(applied_delay), 5);
        chk("pend_spec2", 32'(spec_delay), 33);
        chk("pend_restart", 32'(idelay_rst), 1);
        chk("pend_busy", 32'(busy), 1);
        wait_trig("pend_trig2_seen");
        run_incr(3, 6'd33);
        wait_done("pend_done2_seen");
        chk("pend_applied2", 32'(applied_delay), 33);
        chk("pend_busy_end", 32'(busy), 0);
        repeat (20) tick();
        chk("pend_two_seqs", 32'(trig_cnt - t0), 2);

        // Timeout: ce stuck high after the trigger
        load(6'd40);
        wait_trig("tmo_trig_seen");                    // cycle T
        tick();                                        // T+1
        inc_en_in       = 1'b1;
        actual_delay_in = 6'd40;
        repeat (79) tick();                            // T+80
        chk("tmo_err_early", 32'(err), 0);
        tick();                                        // T+81
        chk("tmo_err", 32'(err), 1);
        chk("tmo_busy", 32'(busy), 1);
        tick();                                        // T+82
        chk("tmo_done", 32'(done), 1);
        chk("tmo_applied", 32'(applied_delay), 33);
        inc_en_in = 1'b0;
        tick();

        // Mismatch: incrementor returns 7 for 8
        load(6'd8);
        chk("mis_err_cleared", 32'(err), 0);
        wait_trig("mis_trig_seen");
        run_incr(2, 6'd7);
        wait_done("mis_done_seen");
        chk("mis_err", 32'(err), 1);
        chk("mis_applied", 32'(applied_delay), 33);
        tick();
        load(6'd8);
        chk("mis_retry_err", 32'(err), 0);
        wait_trig("mis_retry_trig");
        run_incr(2, 6'd8);
        wait_done("mis_retry_done");
        chk("mis_retry_applied", 32'(applied_delay), 8);
        chk("mis_retry_err_end", 32'(err), 0);
        tick();

        // Reset in the middle of COUNT
        load(6'd50);
        wait_trig("rstmid_trig_seen");
        tick();
        inc_en_in       = 1'b1;
        actual_delay_in = 6'd50;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        inc_en_in = 1'b0;
        chk("rstmid_outputs", outs(), 0);
        t0 = trig_cnt;
        r0 = rst_hi_cnt;
        repeat (20) tick();
        chk("rstmid_no_trig", 32'(trig_cnt - t0), 0);
        chk("rstmid_no_idelay_rst", 32'(rst_hi_cnt - r0), 0);
        load(6'd63);
        wait_trig("max_trig_seen");
        run_incr(4, 6'd63);
        wait_done("max_done_seen");
        chk("max_applied", 32'(applied_delay), 63);
        chk("max_err", 32'(err), 0);
        tick();

        // Reset wins over a simultaneous load
        rst        = 1'b1;
        delay_in   = 6'd17;
        delay_load = 1'b1;
        tick();
        rst        = 1'b0;
        delay_load = 1'b0;
        chk("rst_prio_busy", 32'(busy), 0);
        chk("rst_prio_spec", 32'(spec_delay), 0);
        tick();
        chk("rst_prio_idle", 32'(idelay_rst), 0);

        chk("no_overlap", 32'(overlap), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
